io_disp_ctrl: RTL

//   Display/LED controller between the CPU debug bus and the board I/O of top_core.

---
 rtl/io_disp_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/io_disp_ctrl.sv
// -----------------------------------------------------------------------------
// io_disp_ctrl
// Display and LED controller that sits between the CPU debug bus and the board
// I/O. The core writes eight 32-bit debug words (PC, instruction, register
// values, ...). SW selects one of these words, and the controller takes a
// snapshot of it once per scan frame. The two 16-bit halves of the snapshot
// take turns on a 4-digit multiplexed 7-segment display. The low byte of the
// snapshot drives the LEDs.
//
// Ports
//   clk           system clock, single clock domain
//   rst           synchronous, active-high reset
//   SW[2:0]       selects which debug word is displayed
//   bus_we        debug register write strobe
//   bus_addr[2:0] debug register index
//   bus_wdata     debug register write data
//   led_data      low byte of the snapshot, active-high
//   segment_data  {dp,g,f,e,d,c,b,a}, active-low
//   AN[3:0]       digit enables, active-low; AN[0] is the rightmost digit
// -----------------------------------------------------------------------------
module io_disp_ctrl #(
    parameter int SCAN_DIV    = 50000,  // clk cycles per digit slot (>= 2)
    parameter int BLANK       = 16,     // dark cycles at each slot start
    parameter int PAGE_FRAMES = 256     // frames per half-word page
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  SW,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [7:0]  led_data,
    output logic [7:0]  segment_data,
    output logic [3:0]  AN
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C   = CW'(BLANK);
    localparam logic [FW-1:0] FRAME_MAX = FW'(PAGE_FRAMES - 1);

    // Hex digit to segment pattern (gfedcba, active-high).
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [31:0]   regs_q [8];
    logic [31:0]   regs_d [8];
    logic [31:0]   snap_q, snap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          half_q, half_d;
    logic          load_q, load_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    led_q, led_d;

    logic          slot_end;
    logic          frame_end;
    logic [15:0]   shown;
    logic [3:0]    nibble;
    logic          dp_on;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it
        // unassigned and infer a latch.
        regs_d = regs_q;
        if (bus_we) begin
            regs_d[bus_addr] = bus_wdata;
        end

        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (digit_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        digit_d   = slot_end ? digit_q + 2'd1 : digit_q;

        frame_d = frame_q;
        half_d  = half_q;
        if (frame_end) begin
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                half_d  = ~half_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        // The snapshot only changes on a frame boundary, so a frame never
        // tears. A write to the selected word in that same cycle is taken
        // straight from the bus instead of the stale register.
        snap_d = snap_q;
        load_d = load_q;
        if (load_q || frame_end) begin
            snap_d = (bus_we && (bus_addr == SW)) ? bus_wdata : regs_q[SW];
            load_d = 1'b0;
        end

        shown  = half_q ? snap_q[31:16] : snap_q[15:0];
        nibble = shown[{digit_q, 2'b00} +: 4];
        dp_on  = half_q && (digit_q == 2'd3);

        if (cnt_q < BLANK_C) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = {~dp_on, ~hex7(nibble)};
        end
        led_d = snap_q[7:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so that every flop
        // samples values from before the edge.
        if (rst) begin
            // NOTE: the debug register file must read zero after reset, so
            // this small array is reset on purpose; it is flop-based, not RAM.
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            snap_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            frame_q <= '0;
            half_q  <= 1'b0;
            load_q  <= 1'b1;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
            led_q   <= 8'h00;
        end else begin
            regs_q  <= regs_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            half_q  <= half_d;
            load_q  <= load_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            led_q   <= led_d;
        end
    end

    assign AN           = an_q;
    assign segment_data = seg_q;
    assign led_data     = led_q;

endmodule
